// File: rtl/pll_lock_monitor_pkg.sv
// Shared types and default parameters for the PLL lock monitor.
package pll_lock_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcquire,
    StTrack,
    StLocked
  } state_e;

  localparam int unsigned GoodCntW       = 4;
  localparam int unsigned DefaultTol     = 1;
  localparam int unsigned DefaultLockCnt = 4;

endpackage

// File: rtl/osc_edge_sync.sv
// Brings the reference oscillator into the PLL clock domain and flags its rising edge.
module osc_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic osc,
  output logic rise
);

  logic meta_q, sync_q, dly_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= osc;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock detector and period meter, clocked by the PLL output.
// Define PLL_LOCK_MON_STICKY_EN to add the sticky lock_lost flag and its clear input.
module pll_lock_monitor
  import pll_lock_monitor_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TOL      = DefaultTol,
  parameter int unsigned LOCK_CNT = DefaultLockCnt
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             osc,
  input  logic [4:0]       div,
`ifdef PLL_LOCK_MON_STICKY_EN
  input  logic             lock_lost_clr,
  output logic             lock_lost,
`endif
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0]    CntMax     = '1;
  localparam logic [CNT_W-1:0]    CntOne     = CNT_W'(1);
  localparam logic [GoodCntW-1:0] GoodOne    = GoodCntW'(1);
  localparam logic [GoodCntW-1:0] LockTarget = GoodCntW'(LOCK_CNT);

  logic                osc_rise;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    counter_q, counter_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [GoodCntW-1:0] good_q, good_d, good_inc;
  logic                skip_q, skip_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                publish, saturate, sample_good;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]      mag;

  osc_edge_sync u_sync (
    .clock (clock),
    .reset (reset),
    .osc   (osc),
    .rise  (osc_rise)
  );

  // The counter value on an edge is the period just measured.
  assign diff        = $signed({1'b0, counter_q}) - $signed({{(CNT_W-4){1'b0}}, div});
  assign mag         = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
  assign sample_good = mag <= (CNT_W+1)'(TOL);

  // After a saturation the first edge only restarts the count.
  assign publish  = enable && osc_rise && (state_q != StIdle)
                    && !(state_q == StAcquire && skip_q);
  assign saturate = enable && !osc_rise && (state_q != StIdle) && (counter_q == CntMax);

  always_comb begin
    counter_d = counter_q;
    if (!enable || (state_q == StIdle && !osc_rise)) begin
      counter_d = '0;
    end else if (osc_rise) begin
      counter_d = CntOne;
    end else if (counter_q != CntMax) begin
      counter_d = counter_q + CntOne;
    end
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    skip_d   = skip_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    good_inc = good_q + GoodOne;
    if (publish) begin
      count_d = counter_q;
      valid_d = 1'b1;
      err_d   = 1'b0;
    end
    if (!enable) begin
      state_d = StIdle;
      good_d  = '0;
      skip_d  = 1'b0;
    end else if (saturate) begin
      state_d = StAcquire;
      good_d  = '0;
      skip_d  = 1'b1;
      err_d   = 1'b1;
    end else if (osc_rise) begin
      unique case (state_q)
        StIdle: begin
          state_d = StAcquire;
          skip_d  = 1'b0;
        end
        StAcquire: begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            good_d  = sample_good ? GoodOne : '0;
            state_d = (sample_good && GoodOne >= LockTarget) ? StLocked : StTrack;
          end
        end
        StTrack: begin
          if (sample_good) begin
            good_d  = good_inc;
            state_d = (good_inc >= LockTarget) ? StLocked : StTrack;
          end else begin
            good_d = '0;
          end
        end
        StLocked: begin
          if (!sample_good) begin
            state_d = StTrack;
            good_d  = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      counter_q <= '0;
      good_q    <= '0;
      skip_q    <= 1'b0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      good_q    <= good_d;
      skip_q    <= skip_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign err         = err_q;
  assign locked      = (state_q == StLocked);

`ifdef PLL_LOCK_MON_STICKY_EN
  logic lost_q, lost_set;

  // Leaving LOCKED for anything but IDLE means the lock was genuinely lost.
  assign lost_set = (state_q == StLocked) && (state_d == StTrack || state_d == StAcquire);

  always_ff @(posedge clock) begin
    if (reset) begin
      lost_q <= 1'b0;
    end else if (lost_set) begin
      lost_q <= 1'b1;
    end else if (lock_lost_clr) begin
      lost_q <= 1'b0;
    end
  end

  assign lock_lost = lost_q;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: cycle-by-cycle model comparison plus literal checkpoints.
module tb_pll_lock_monitor;

  localparam int CntW    = 8;
  localparam int Tol     = 1;
  localparam int LockCnt = 4;
  localparam int Max     = 255;
  localparam int MIdle = 0, MAcq = 1, MTrack = 2, MLocked = 3;

  logic            clock = 1'b0;
  logic            reset, enable, osc, lock_lost_clr;
  logic [4:0]      div;
  logic [CntW-1:0] count;
  logic            count_valid, locked, err;
`ifdef PLL_LOCK_MON_STICKY_EN
  logic            lock_lost;
`endif

  pll_lock_monitor dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .osc           (osc),
    .div           (div),
`ifdef PLL_LOCK_MON_STICKY_EN
    .lock_lost_clr (lock_lost_clr),
    .lock_lost     (lock_lost),
`endif
    .count         (count),
    .count_valid   (count_valid),
    .locked        (locked),
    .err           (err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;

  // Model: the current period is the cycle distance from the last restart edge.
  int cyc = 0, m_start = 0, m_run = 0, m_mode = MIdle;
  bit o1, o2, o3, m_skip, m_init;
  logic [CntW-1:0] e_count;
  logic e_valid, e_locked, e_err, e_lost;

  int tick_n = 0, pub_total = 0, lock_pub = 0, last_pub_tick = 0, err_rise_tick = 0;
  bit prev_locked, prev_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit e, good, set_l;
    int el, d;
    cyc++;
    if (reset) begin
      o1 = 0; o2 = 0; o3 = 0;
      m_mode = MIdle; m_start = cyc; m_skip = 0; m_run = 0;
      e_count = '0; e_valid = 0; e_locked = 0; e_err = 0; e_lost = 0;
      m_init = 1;
      return;
    end
    e  = o2 && !o3;
    o3 = o2; o2 = o1; o1 = osc;
    el = cyc - m_start;
    if (el > Max) el = Max;
    e_valid = 0;
    set_l   = 0;
    if (!enable) begin
      m_mode = MIdle;
    end else if (m_mode == MIdle) begin
      if (e) begin
        m_mode = MAcq; m_start = cyc; m_skip = 0;
      end
    end else if (e) begin
      if (m_skip) begin
        m_skip = 0;
      end else begin
        d = el - int'(div);
        good = (d <= Tol) && (d >= -Tol);
        e_count = CntW'(el); e_valid = 1; e_err = 0;
        if (m_mode == MLocked) begin
          if (!good) begin
            m_mode = MTrack; m_run = 0; set_l = 1;
          end
        end else begin
          m_run  = good ? ((m_mode == MAcq) ? 1 : m_run + 1) : 0;
          m_mode = (m_run >= LockCnt) ? MLocked : MTrack;
        end
      end
      m_start = cyc;
    end else if (el >= Max) begin
      e_err = 1;
      if (m_mode == MLocked) set_l = 1;
      m_mode = MAcq; m_skip = 1; m_run = 0;
    end
    if (set_l) e_lost = 1;
    else if (lock_lost_clr) e_lost = 0;
    e_locked = (m_mode == MLocked);
  endtask

  // One clock: model follows the active edge, DUT is compared on the falling edge.
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    tick_n++;
    if (m_init) begin
      check("cyc_count", count, e_count);
      check("cyc_valid", count_valid, e_valid);
      check("cyc_locked", locked, e_locked);
      check("cyc_err", err, e_err);
`ifdef PLL_LOCK_MON_STICKY_EN
      check("cyc_lock_lost", lock_lost, e_lost);
`endif
    end
    if (count_valid === 1'b1) begin
      pub_total++;
      last_pub_tick = tick_n;
    end
    if (locked === 1'b1 && !prev_locked) lock_pub = pub_total;
    if (err === 1'b1 && !prev_err) err_rise_tick = tick_n;
    prev_locked = (locked === 1'b1);
    prev_err    = (err === 1'b1);
  endtask

  task automatic period(input int p);
    osc = 1'b1;
    repeat (p / 2) tick();
    osc = 1'b0;
    repeat (p - p / 2) tick();
  endtask

  initial begin
    int base;
    bit seen;
    reset = 1'b1; enable = 1'b0; osc = 1'b0; div = 5'd8; lock_lost_clr = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_count", count, 0);
    check("reset_valid", count_valid, 0);
    check("reset_locked", locked, 0);
    check("reset_err", err, 0);

    // Acquire with exact period 8
    base = pub_total;
    enable = 1'b1;
    repeat (7) period(8);
    check("acq_locked", locked, 1);
    check("acq_count", count, 8);
    check("acq_lock_at_sample", lock_pub - base, 4);

    // Missing reference
    repeat (300) tick();
    check("sat_delay", err_rise_tick - last_pub_tick, 255);
    check("sat_err", err, 1);
    check("sat_locked", locked, 0);
`ifdef PLL_LOCK_MON_STICKY_EN
    check("sat_lock_lost", lock_lost, 1);
    lock_lost_clr = 1'b1; tick(); lock_lost_clr = 1'b0; tick();
    check("sat_lost_cleared", lock_lost, 0);
`endif
    base = pub_total;
    period(8);
    check("restart_silent", pub_total - base, 0);
    check("restart_err_held", err, 1);
    period(8);
    check("restart_pub", pub_total - base, 1);
    check("restart_count", count, 8);
    check("restart_err_clr", err, 0);

    // Tolerance boundaries around div=10
    div = 5'd10;
    for (int i = 0; i < 6; i++) period((i % 2 == 0) ? 9 : 11);
    check("tol_locked", locked, 1);
    period(12);
    period(10);
    check("tol_unlocked", locked, 0);
    check("tol_count", count, 12);
`ifdef PLL_LOCK_MON_STICKY_EN
    check("tol_lock_lost", lock_lost, 1);
    lock_lost_clr = 1'b1; tick(); lock_lost_clr = 1'b0; tick();
    check("tol_lost_cleared", lock_lost, 0);
    repeat (5) period(10);
    check("race_relocked", locked, 1);
    period(13);
    osc = 1'b1; lock_lost_clr = 1'b1;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (count_valid === 1'b1) begin
        seen = 1;
        check("race_set_wins", lock_lost, 1);
      end
    end
    check("race_seen", seen, 1);
    tick();
    check("clr_alone", lock_lost, 0);
    lock_lost_clr = 1'b0; osc = 1'b0;
    repeat (4) tick();
`endif

    // Disable after two good samples, then reacquire
    enable = 1'b0;
    repeat (3) tick();
    base = pub_total;
    enable = 1'b1;
    period(10);
    period(10);
    osc = 1'b1;
    repeat (5) tick();
    osc = 1'b0; enable = 1'b0;
    repeat (5) tick();
    check("dis_two_samples", pub_total - base, 2);
    check("dis_locked", locked, 0);
    repeat (20) tick();
    check("dis_count_held", count, 10);
    base = pub_total;
    enable = 1'b1;
    repeat (7) period(10);
    check("reen_lock_at_sample", lock_pub - base, 4);
    check("reen_locked", locked, 1);

    // Reset mid-period
    osc = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("midrst_count", count, 0);
    check("midrst_valid", count_valid, 0);
    check("midrst_locked", locked, 0);
    check("midrst_err", err, 0);
    reset = 1'b0; osc = 1'b0;
    repeat (3) tick();

    // Frequency sweep around div=16
    div = 5'd16;
    for (int p = 13; p <= 19; p++) begin
      enable = 1'b0;
      repeat (3) tick();
      enable = 1'b1;
      repeat (7) period(p);
      check($sformatf("sweep_locked_%0d", p), locked, (p >= 15 && p <= 17) ? 1 : 0);
      check($sformatf("sweep_count_%0d", p), count, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
